sram_bank_arbiter: RTL
======================

# sram_bank_arbiter

Parametrised ownership arbiter between the host (testbench/loader) port and the corelet port for a set of single-port SRAM banks. It replaces the static select-line mux in front of the activation, weight and output SRAMs with a handshaked ownership protocol. The protocol has drain states, per-bank read-return tracking with valid strobes, and detection of illegal accesses. It sits in `core`, between the host/corelet request ports and the SRAM macros.

## Interface
- `BANKS`, 3, number of SRAM banks arbitrated.
- `DW`, 32, data width per bank.
- `AW`, 7, address width per bank.
- `RD_LAT`, 1, SRAM read latency in cycles (≥1).

Bank b occupies bits [b*DW +: DW] of every packed data bus, bits [b*AW +: AW] of every address bus, and bit b of every 1-bit-per-bank bus.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `host_req` in 1: host requests ownership of all banks (level).
- `core_busy` in 1: corelet has a sequence in flight; ownership must not be taken.
- `host_gnt` out 1: host owns the banks.
- `core_gnt` out 1: corelet owns the banks.
- `host_d` / `core_d` in BANKS*DW: write data.
- `host_addr` / `core_addr` in BANKS*AW: address.
- `host_cen` / `core_cen` in BANKS: chip enable, active-low.
- `host_wen` / `core_wen` in BANKS: write enable, active-low (1 = read).
- `mem_d` out BANKS*DW, `mem_addr` out BANKS*AW, `mem_cen` out BANKS, `mem_wen` out BANKS: to SRAM macros.
- `mem_q` in BANKS*DW: SRAM read data.
- `host_q` / `core_q` out BANKS*DW: read data, equal to `mem_q`.
- `host_q_valid` / `core_q_valid` out BANKS: read-return strobes.
- `viol_host` / `viol_core` out 1: sticky illegal-access flags.
- `viol_cnt` out 8: saturating count of dropped illegal accesses.

## Operation
- States: HOST_OWN, DRAIN_TO_CORE, CORE_OWN, DRAIN_TO_HOST. Reset state is HOST_OWN.
- HOST_OWN: `host_req`=0 → DRAIN_TO_CORE.
- CORE_OWN: `host_req`=1 and `core_busy`=0 → DRAIN_TO_HOST. While `core_busy`=1, stay in CORE_OWN regardless of `host_req`.
- Drain states: a counter loads `RD_LAT` on entry and decrements each cycle.
  - Exit when the counter is 1. Each drain therefore lasts exactly `RD_LAT` cycles.
  - DRAIN_TO_CORE → CORE_OWN; DRAIN_TO_HOST → HOST_OWN.
  - Drains are never aborted. If `host_req` changes during a drain, the drain completes and the FSM re-evaluates in the owner state.
- `host_gnt` = (state == HOST_OWN) and `core_gnt` = (state == CORE_OWN). Both decode the state register directly, with no combinational path from inputs.
- Mux, per bank, combinational from state:
  - Owner state: `mem_*` = owner's d/addr/cen/wen.
  - Drain state: `mem_cen`=all 1, `mem_wen`=all 1, `mem_addr`/`mem_d` = 0.
- Read tracking:
  - A read is issued on bank b when the granted side drives cen[b]=0 and wen[b]=1.
  - Per bank, an `RD_LAT`-deep shift pipeline carries {valid, owner tag}.
  - `<tag>_q_valid[b]` pulses for one cycle exactly `RD_LAT` cycles after issue.
  - The return goes to the tagged side even if ownership has since changed.
- Writes (cen=0, wen=0) produce no valid strobe.
- Illegal access: cen[b]=0 from a non-granted side, in any state including drains.
  - The access is dropped and never reaches `mem_*`.
  - The matching `viol_*` flag sets and stays set until reset.
  - `viol_cnt` increments by the number of offending banks, summed over both sides, in that cycle. It saturates at 255.

## Timing
- Reset values:
  - State: HOST_OWN, so `host_gnt`=1 and `core_gnt`=0.
  - All `*_q_valid`=0, `viol_host`=0, `viol_core`=0, `viol_cnt`=0.
  - Read pipelines and drain counter cleared.
  - `mem_*` follow the host ports.
- Reset asserted mid-drain or mid-read: return to HOST_OWN immediately, and pending valid strobes are discarded.
- Handover latency, counted from the first cycle `host_req`=0 is sampled in HOST_OWN:
  - `host_gnt` drops on the next cycle.
  - `core_gnt` rises `RD_LAT`+1 cycles after sampling.
  - The reverse direction behaves the same, once `core_busy`=0 is also sampled.
- Read issued in the last owner cycle T: valid at T+`RD_LAT`, the final drain cycle. The new owner's first access is at T+`RD_LAT`+1.
- Read on bank 0 and write on bank 1 in the same cycle: independent; only bank 0 strobes.

## Test plan
- Reset, then the host writes 0xDEADBEEF to bank 0, addr 5, and reads it back → `host_q_valid[0]` pulses 1 cycle after the read with `host_q[31:0]`=0xDEADBEEF. `core_q_valid`=0 throughout.
- Drop `host_req` with `RD_LAT`=1 → `host_gnt` falls next cycle, exactly 1 drain cycle with `mem_cen`=3'b111, then `core_gnt`=1.
- `core_busy`=1 in CORE_OWN while `host_req`=1 → `core_gnt` is held. Drop `core_busy` → `host_gnt`=1 after 1 drain cycle.
- Core reads bank 2 in its last owner cycle before handover (`RD_LAT`=2) → `core_q_valid[2]` pulses in the second drain cycle, and `host_q_valid` stays 0.
- The core drives cen=3'b010 while the host is granted, on 300 consecutive cycles → SRAM is untouched, `viol_core`=1, `viol_host`=0, `viol_cnt`=255 (saturated).
- Reset asserted during DRAIN_TO_CORE with a read pending → `host_gnt`=1 and all valids 0 immediately, and no strobe after reset release.

Source files
------------

// File: rtl/sram_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arbiter_if
// Description : Bus bundle between the host port, the corelet port, the SRAM
//               macros and the bank ownership arbiter.
//               Bank b occupies [b*DW +: DW] of data buses, [b*AW +: AW] of
//               address buses and bit b of every per-bank strobe bus.
// Ports       : host_req/core_busy/host_gnt/core_gnt - ownership handshake
//               host_*/core_*  - requester d/addr/cen/wen, q/q_valid returns
//               mem_*          - SRAM macro side (d/addr/cen/wen out, q in)
//               viol_*         - sticky illegal-access flags and counter
//               modport slave  : the arbiter
//               modport master : requesters and SRAM macros
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bank_arbiter_if #(
    parameter int BANKS = 3,
    parameter int DW    = 32,
    parameter int AW    = 7
);
    logic                  host_req;
    logic                  core_busy;
    logic                  host_gnt;
    logic                  core_gnt;

    logic [BANKS*DW-1:0]   host_d;
    logic [BANKS*AW-1:0]   host_addr;
    logic [BANKS-1:0]      host_cen;
    logic [BANKS-1:0]      host_wen;
    logic [BANKS*DW-1:0]   host_q;
    logic [BANKS-1:0]      host_q_valid;

    logic [BANKS*DW-1:0]   core_d;
    logic [BANKS*AW-1:0]   core_addr;
    logic [BANKS-1:0]      core_cen;
    logic [BANKS-1:0]      core_wen;
    logic [BANKS*DW-1:0]   core_q;
    logic [BANKS-1:0]      core_q_valid;

    logic [BANKS*DW-1:0]   mem_d;
    logic [BANKS*AW-1:0]   mem_addr;
    logic [BANKS-1:0]      mem_cen;
    logic [BANKS-1:0]      mem_wen;
    logic [BANKS*DW-1:0]   mem_q;

    logic                  viol_host;
    logic                  viol_core;
    logic [7:0]            viol_cnt;

    modport slave (
        input  host_req, core_busy,
        input  host_d, host_addr, host_cen, host_wen,
        input  core_d, core_addr, core_cen, core_wen,
        input  mem_q,
        output host_gnt, core_gnt,
        output host_q, host_q_valid, core_q, core_q_valid,
        output mem_d, mem_addr, mem_cen, mem_wen,
        output viol_host, viol_core, viol_cnt
    );

    modport master (
        output host_req, core_busy,
        output host_d, host_addr, host_cen, host_wen,
        output core_d, core_addr, core_cen, core_wen,
        output mem_q,
        input  host_gnt, core_gnt,
        input  host_q, host_q_valid, core_q, core_q_valid,
        input  mem_d, mem_addr, mem_cen, mem_wen,
        input  viol_host, viol_core, viol_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arbiter
// Description : Ownership arbiter for a set of single-port SRAM banks shared
//               by the host (loader) port and the corelet port. Ownership is
//               handed over through a drain phase of RD_LAT cycles in which
//               the macros are idle, so in-flight reads return cleanly. Each
//               read return is tagged with the side that issued it. Accesses
//               from the side that does not own the banks are dropped and
//               recorded.
// Ports       : clk   - clock, all state on the rising edge
//               reset - asynchronous, active-low
//               bus   - sram_bank_arbiter_if.slave (handshake, host/core
//                       request ports, SRAM macro port, violation status)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_arbiter #(
    parameter int BANKS  = 3,
    parameter int DW     = 32,
    parameter int AW     = 7,
    parameter int RD_LAT = 1
) (
    input wire                 clk,
    input wire                 reset,
    sram_bank_arbiter_if.slave bus
);

    // Drain counter must hold RD_LAT; violation popcount must hold 2*BANKS.
    localparam int c_CW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam int c_PW = $clog2(2 * BANKS + 1);

    typedef enum logic [1:0] {
        HOST_OWN      = 2'd0,
        DRAIN_TO_CORE = 2'd1,
        CORE_OWN      = 2'd2,
        DRAIN_TO_HOST = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CW-1:0]     r_drain_cnt;
    logic [c_CW-1:0]     w_drain_cnt_next;

    logic                w_host_own;
    logic                w_core_own;

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    assign w_host_own = (r_state == HOST_OWN);
    assign w_core_own = (r_state == CORE_OWN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= HOST_OWN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // The counter is loaded on the owner->drain transition, so the first
    // drain cycle sees RD_LAT and the drain exits on the cycle it reads 1.
    // Drains always run to completion; requests are re-evaluated only once
    // an owner state is reached again.
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        case (r_state)
            HOST_OWN: begin
                if (!bus.host_req) begin
                    w_state_next     = DRAIN_TO_CORE;
                    w_drain_cnt_next = c_CW'(RD_LAT);
                end
            end
            DRAIN_TO_CORE: begin
                if (r_drain_cnt == c_CW'(1)) begin
                    w_state_next     = CORE_OWN;
                    w_drain_cnt_next = '0;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - c_CW'(1);
                end
            end
            CORE_OWN: begin
                if (bus.host_req && !bus.core_busy) begin
                    w_state_next     = DRAIN_TO_HOST;
                    w_drain_cnt_next = c_CW'(RD_LAT);
                end
            end
            DRAIN_TO_HOST: begin
                if (r_drain_cnt == c_CW'(1)) begin
                    w_state_next     = HOST_OWN;
                    w_drain_cnt_next = '0;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - c_CW'(1);
                end
            end
            default: begin
                w_state_next     = HOST_OWN;
                w_drain_cnt_next = '0;
            end
        endcase
    end

    // Grants decode the state register only, never the request inputs.
    assign bus.host_gnt = w_host_own;
    assign bus.core_gnt = w_core_own;

    // ------------------------------------------------------------------
    // SRAM port mux: only the owner reaches the macros; during a drain the
    // macros are held deselected with a quiet bus.
    // ------------------------------------------------------------------
    logic [BANKS*DW-1:0] w_mem_d;
    logic [BANKS*AW-1:0] w_mem_addr;
    logic [BANKS-1:0]    w_mem_cen;
    logic [BANKS-1:0]    w_mem_wen;

    always_comb begin
        w_mem_d    = '0;
        w_mem_addr = '0;
        w_mem_cen  = '1;
        w_mem_wen  = '1;
        if (w_host_own) begin
            w_mem_d    = bus.host_d;
            w_mem_addr = bus.host_addr;
            w_mem_cen  = bus.host_cen;
            w_mem_wen  = bus.host_wen;
        end else if (w_core_own) begin
            w_mem_d    = bus.core_d;
            w_mem_addr = bus.core_addr;
            w_mem_cen  = bus.core_cen;
            w_mem_wen  = bus.core_wen;
        end
    end

    assign bus.mem_d    = w_mem_d;
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_cen  = w_mem_cen;
    assign bus.mem_wen  = w_mem_wen;

    // Both sides see the raw macro data; the valid strobes say whose it is.
    assign bus.host_q = bus.mem_q;
    assign bus.core_q = bus.mem_q;

    // ------------------------------------------------------------------
    // Read-return tracking: per bank, an RD_LAT-deep pipeline of
    // {valid, tag}. Tag 1 means the corelet issued the read. The tag is
    // captured at issue time so a return that lands after an ownership
    // change still goes to the side that asked for it.
    // ------------------------------------------------------------------
    logic [BANKS-1:0]                 w_rd_issue;
    logic [RD_LAT-1:0][BANKS-1:0]     r_pipe_vld;
    logic [RD_LAT-1:0][BANKS-1:0]     r_pipe_tag;

    assign w_rd_issue = ({BANKS{w_host_own}} & ~bus.host_cen & bus.host_wen)
                      | ({BANKS{w_core_own}} & ~bus.core_cen & bus.core_wen);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= '0;
            r_pipe_tag <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            r_pipe_tag[0] <= {BANKS{w_core_own}};
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    assign bus.host_q_valid = r_pipe_vld[RD_LAT-1] & ~r_pipe_tag[RD_LAT-1];
    assign bus.core_q_valid = r_pipe_vld[RD_LAT-1] &  r_pipe_tag[RD_LAT-1];

    // ------------------------------------------------------------------
    // Illegal-access detection. A side that does not own the banks (both
    // sides during a drain) must keep every cen high; any low cen is an
    // access that the mux above has already dropped.
    // ------------------------------------------------------------------
    logic [BANKS-1:0] w_ill_host;
    logic [BANKS-1:0] w_ill_core;
    logic [c_PW-1:0]  w_ill_cnt;
    logic [15:0]      w_cnt_sum;
    logic [7:0]       w_viol_cnt_next;
    logic             r_viol_host;
    logic             r_viol_core;
    logic [7:0]       r_viol_cnt;

    assign w_ill_host = ~bus.host_cen & {BANKS{~w_host_own}};
    assign w_ill_core = ~bus.core_cen & {BANKS{~w_core_own}};

    always_comb begin
        w_ill_cnt = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_ill_cnt = w_ill_cnt + c_PW'(w_ill_host[b]) + c_PW'(w_ill_core[b]);
        end
    end

    // Saturating add at 255.
    assign w_cnt_sum       = 16'(r_viol_cnt) + 16'(w_ill_cnt);
    assign w_viol_cnt_next = (w_cnt_sum > 16'd255) ? 8'hFF : w_cnt_sum[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_viol_host <= 1'b0;
            r_viol_core <= 1'b0;
            r_viol_cnt  <= '0;
        end else begin
            r_viol_host <= r_viol_host | (|w_ill_host);
            r_viol_core <= r_viol_core | (|w_ill_core);
            r_viol_cnt  <= w_viol_cnt_next;
        end
    end

    assign bus.viol_host = r_viol_host;
    assign bus.viol_core = r_viol_core;
    assign bus.viol_cnt  = r_viol_cnt;

endmodule
`default_nettype wire
